jtcontra_gfx_romrq: RTL and testbench

JTCONTRA_GFX_ROMRQ -- requirements
Module: jtcontra_gfx_romrq

---
 rtl/jtcontra_gfx_romrq.sv | 189 ++++++++++++++++++
 tb/tb_jtcontra_gfx_romrq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_gfx_romrq.sv
// Graphics ROM request bridge: turns graphics-chip word reads into SDRAM
// fetches, optionally backed by a two-entry tag/data cache.
// Optional feature macro: JTCONTRA_ROMRQ_CACHE_EN (defined = cache present).
module jtcontra_gfx_romrq #(
  parameter logic [21:0] SCR_OFFSET = 22'h0,
  parameter logic [21:0] OBJ_OFFSET = 22'h4_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_cs,
  input  logic [17:0] rom_addr,
  input  logic        rom_obj_sel,
  output logic        rom_ok,
  output logic [15:0] rom_data,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_din
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 22;
  localparam int unsigned TW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic            rom_ok_q, rom_ok_d;
  logic [DW-1:0]   rom_data_q, rom_data_d;
  logic            sdram_req_q, sdram_req_d;
  logic [SW-1:0]   sdram_addr_q, sdram_addr_d;
  logic [TW-1:0]   req_tag_q, req_tag_d;
  logic [TW-1:0]   ok_tag_q, ok_tag_d;

  logic [TW-1:0]   live_tag_c;
  logic [SW-1:0]   fetch_addr_c;
  logic            keep_c;
  logic            hit_c;
  logic [DW-1:0]   hit_data_c;
  logic            fill_c;

  // Live request tag and its SDRAM word address
  always_comb begin
    live_tag_c   = {rom_obj_sel, rom_addr};
    fetch_addr_c = SW'(rom_addr) + (rom_obj_sel ? OBJ_OFFSET : SCR_OFFSET);
    keep_c       = rom_ok_q && rom_cs && (live_tag_c == ok_tag_q);
  end

`ifdef JTCONTRA_ROMRQ_CACHE_EN
  logic [TW-1:0] ctag_q  [2];
  logic [TW-1:0] ctag_d  [2];
  logic [DW-1:0] cdata_q [2];
  logic [DW-1:0] cdata_d [2];
  logic [1:0]    valid_q, valid_d;
  logic          ptr_q, ptr_d;
  logic          hit0_c, hit1_c;

  // Cache lookup against the live tag
  always_comb begin
    hit0_c     = valid_q[0] && (ctag_q[0] == live_tag_c);
    hit1_c     = valid_q[1] && (ctag_q[1] == live_tag_c);
    hit_c      = hit0_c || hit1_c;
    hit_data_c = hit0_c ? cdata_q[0] : cdata_q[1];
  end

  // Cache fill at the replacement pointer, pointer alternates per fill
  always_comb begin
    ctag_d  = ctag_q;
    cdata_d = cdata_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (fill_c) begin
      ctag_d[ptr_q]  = req_tag_q;
      cdata_d[ptr_q] = sdram_din;
      valid_d[ptr_q] = 1'b1;
      ptr_d          = ~ptr_q;
    end
  end

  // Cache storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctag_q[0]  <= '0;
      ctag_q[1]  <= '0;
      cdata_q[0] <= '0;
      cdata_q[1] <= '0;
      valid_q    <= '0;
      ptr_q      <= 1'b0;
    end else begin
      ctag_q  <= ctag_d;
      cdata_q <= cdata_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end
`else
  // No storage: every fresh request goes to SDRAM
  always_comb begin
    hit_c      = 1'b0;
    hit_data_c = '0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a fetch, once started, always runs to sdram_dst
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rom_cs && !keep_c && !hit_c) state_d = S_REQ;
      S_REQ:  if (sdram_ack) state_d = S_WAIT;
      S_WAIT: if (sdram_dst) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    rom_ok_d     = 1'b0;
    rom_data_d   = rom_data_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    req_tag_d    = req_tag_q;
    ok_tag_d     = ok_tag_q;
    fill_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rom_cs) begin
          if (keep_c) begin
            rom_ok_d = 1'b1;
          end else if (hit_c) begin
            rom_ok_d   = 1'b1;
            rom_data_d = hit_data_c;
            ok_tag_d   = live_tag_c;
          end else begin
            req_tag_d    = live_tag_c;
            sdram_addr_d = fetch_addr_c;
            sdram_req_d  = 1'b1;
          end
        end
      end
      S_REQ: begin
        sdram_req_d = !sdram_ack;
      end
      S_WAIT: begin
        if (sdram_dst) begin
          fill_c = 1'b1;
          if (rom_cs && (req_tag_q == live_tag_c)) begin
            rom_ok_d   = 1'b1;
            rom_data_d = sdram_din;
            ok_tag_d   = live_tag_c;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_ok_q     <= 1'b0;
      rom_data_q   <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      req_tag_q    <= '0;
      ok_tag_q     <= '0;
    end else begin
      rom_ok_q     <= rom_ok_d;
      rom_data_q   <= rom_data_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      req_tag_q    <= req_tag_d;
      ok_tag_q     <= ok_tag_d;
    end
  end

  assign rom_ok     = rom_ok_q;
  assign rom_data   = rom_data_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtcontra_gfx_romrq.sv
// Bench for jtcontra_gfx_romrq: transaction-level model with FIFO-ordered
// cache, per-cycle comparison, plus hand-computed literal expectations.
module tb_jtcontra_gfx_romrq;

  localparam logic [21:0] SCR = 22'h0;
  localparam logic [21:0] OBJ = 22'h4_0000;
`ifdef JTCONTRA_ROMRQ_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_cs = 1'b0;
  logic [17:0] rom_addr = '0;
  logic        rom_obj_sel = 1'b0;
  logic        rom_ok;
  logic [15:0] rom_data;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [15:0] sdram_din = '0;

  int n_chk  = 0;
  int n_pass = 0;

  jtcontra_gfx_romrq #(.SCR_OFFSET(SCR), .OBJ_OFFSET(OBJ)) dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_obj_sel(rom_obj_sel), .rom_ok(rom_ok), .rom_data(rom_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: one outstanding fetch record, cache as oldest-first list
  logic        m_ok = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_req = 1'b0;
  logic [21:0] m_addr = '0;
  logic [18:0] m_tag = '0;
  bit          f_active = 1'b0;
  bit          f_acked = 1'b0;
  logic [18:0] f_tag = '0;
  logic [18:0] m_ctag[$];
  logic [15:0] m_cdata[$];

  always @(posedge clk) begin : model
    logic [18:0] live;
    bit          hit;
    logic [15:0] hd;
    live = {rom_obj_sel, rom_addr};
    hit  = 1'b0;
    hd   = '0;
    if (rst) begin
      m_ok = 0; m_data = '0; m_req = 0; m_addr = '0;
      f_active = 0; f_acked = 0;
      m_ctag.delete(); m_cdata.delete();
    end else if (f_active && !f_acked) begin
      m_ok = 0;
      if (sdram_ack) begin f_acked = 1; m_req = 0; end
    end else if (f_active) begin
      m_ok = 0;
      if (sdram_dst) begin
        f_active = 0;
        if (CACHE_ON) begin
          m_ctag.push_back(f_tag);
          m_cdata.push_back(sdram_din);
          if (m_ctag.size() > 2) begin
            void'(m_ctag.pop_front());
            void'(m_cdata.pop_front());
          end
        end
        if (rom_cs && f_tag == live) begin
          m_ok = 1; m_data = sdram_din; m_tag = live;
        end
      end
    end else if (!rom_cs) begin
      m_ok = 0;
    end else if (!(m_ok && live == m_tag)) begin
      foreach (m_ctag[i]) if (m_ctag[i] == live) begin hit = 1; hd = m_cdata[i]; end
      if (hit) begin
        m_ok = 1; m_data = hd; m_tag = live;
      end else begin
        f_active = 1; f_acked = 0; f_tag = live;
        m_addr = 22'(rom_addr) + (rom_obj_sel ? OBJ : SCR);
        m_req = 1; m_ok = 0;
      end
    end
    #1;
    check("m_rom_ok", 32'(rom_ok), 32'(m_ok));
    check("m_rom_data", 32'(rom_data), 32'(m_data));
    check("m_sdram_req", 32'(sdram_req), 32'(m_req));
    check("m_sdram_addr", 32'(sdram_addr), 32'(m_addr));
  end

  task automatic drive_req(input logic sel, input logic [17:0] a);
    @(negedge clk);
    rom_cs = 1'b1; rom_obj_sel = sel; rom_addr = a;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!sdram_req && n < 20);
    check("req_seen", 32'(sdram_req), 32'd1);
  endtask

  task automatic ack_dst(input logic [15:0] din);
    @(negedge clk); sdram_ack = 1'b1;
    @(negedge clk); sdram_ack = 1'b0;
    @(negedge clk); sdram_dst = 1'b1; sdram_din = din;
    @(negedge clk); sdram_dst = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] din, input logic [21:0] exp_addr, input string nm);
    wait_req();
    check({nm, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
    ack_dst(din);
    check({nm, "_ok"}, 32'(rom_ok), 32'd1);
    check({nm, "_data"}, 32'(rom_data), 32'(din));
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk);
    check("rst_ok", 32'(rom_ok), 32'd0);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_data", 32'(rom_data), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    rst = 1'b0;

    // basic tile fetch
    drive_req(1'b0, 18'h00123);
    fetch(16'hBEEF, 22'h000123, "t1");
    repeat (3) @(negedge clk);
    check("t1_hold", 32'(rom_ok), 32'd1);

    // stray ack/dst while idle are ignored
    sdram_ack = 1'b1;
    @(negedge clk); sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_din = 16'hDEAD;
    @(negedge clk); sdram_dst = 1'b0;
    check("stray_ok", 32'(rom_ok), 32'd1);
    check("stray_data", 32'(rom_data), 32'h0000BEEF);

    // object fetch, then revisit the tile word
    drive_req(1'b1, 18'h00010);
    fetch(16'h1111, 22'h040010, "obj");
    drive_req(1'b0, 18'h00123);
    if (CACHE_ON) begin
      @(posedge clk); #2;
      check("hit_ok", 32'(rom_ok), 32'd1);
      check("hit_data", 32'(rom_data), 32'h0000BEEF);
      check("hit_noreq", 32'(sdram_req), 32'd0);
    end else begin
      fetch(16'hBEEF, 22'h000123, "refetch");
    end

    // address changes while waiting for data
    drive_req(1'b0, 18'h00300);
    wait_req();
    check("stale_addr", 32'(sdram_addr), 32'h000300);
    @(negedge clk); sdram_ack = 1'b1;
    @(negedge clk); sdram_ack = 1'b0; rom_addr = 18'h00200;
    @(negedge clk); sdram_dst = 1'b1; sdram_din = 16'h3333;
    @(negedge clk); sdram_dst = 1'b0;
    check("stale_ok", 32'(rom_ok), 32'd0);
    fetch(16'h2222, 22'h000200, "second");

    // A, B, C evict A; C still resident
    drive_req(1'b0, 18'h00400); fetch(16'hA000, 22'h000400, "fa");
    drive_req(1'b0, 18'h00401); fetch(16'hB000, 22'h000401, "fb");
    drive_req(1'b0, 18'h00402); fetch(16'hC000, 22'h000402, "fc");
    drive_req(1'b0, 18'h00400); fetch(16'hA001, 22'h000400, "fa2");
    drive_req(1'b0, 18'h00402);
    if (CACHE_ON) begin
      @(posedge clk); #2;
      check("c_hit_ok", 32'(rom_ok), 32'd1);
      check("c_hit_data", 32'(rom_data), 32'h0000C000);
    end else begin
      fetch(16'hC000, 22'h000402, "fc2");
    end

    // reset during WAIT abandons the fetch
    drive_req(1'b0, 18'h00500);
    wait_req();
    @(negedge clk); sdram_ack = 1'b1;
    @(negedge clk); sdram_ack = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; rom_cs = 1'b0;
    @(negedge clk); sdram_dst = 1'b1; sdram_din = 16'h5555;
    @(negedge clk); sdram_dst = 1'b0;
    check("rstw_ok", 32'(rom_ok), 32'd0);
    check("rstw_data", 32'(rom_data), 32'd0);
    drive_req(1'b0, 18'h00500);
    fetch(16'h5A5A, 22'h000500, "after_rst");

    // dropping rom_cs clears rom_ok; repeat request
    @(negedge clk); rom_cs = 1'b0;
    @(posedge clk); #2;
    check("cs_drop_ok", 32'(rom_ok), 32'd0);
    drive_req(1'b0, 18'h00500);
    if (CACHE_ON) begin
      @(posedge clk); #2;
      check("rep_hit_ok", 32'(rom_ok), 32'd1);
      check("rep_hit_noreq", 32'(sdram_req), 32'd0);
    end else begin
      fetch(16'h6666, 22'h000500, "rep_fetch");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
